unrom_bank_ctrl: RTL
====================

Name: unrom_bank_ctrl

Overview:
Synchronous UNROM bank controller for the cartridge CPLD/FPGA, clocked from a free-running system clock.
- Oversamples the asynchronous CPU cartridge bus (M2, R/W, /ROMSEL, D) and qualifies genuine CPU write cycles to $8000-$FFFF with a glitch filter.
- Applies NES bus-conflict masking and commits the bank number.
- Drives PRG high address lines: switchable 16 KiB bank at $8000-$BFFF, fixed last bank at $C000-$FFFF.

Parameters:
BANK_BITS, 4, width of bank register and prg_a output (16 banks = 256 KiB PRG)
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2)
MIN_LOW, 3, consecutive synchronized clk samples with /ROMSEL low and R/W low required before a write is eligible (range 1..15)
BUS_CONFLICT, 1, 1 = committed value is cpu_d AND rom_d; 0 = cpu_d only

Ports:
clk  input  1  system clock, at least 8x M2 (nominal 21.477 MHz)
rst  input  1  synchronous, active-high reset
m2  input  1  CPU M2 phase, asynchronous
Ncpu_rw  input  1  CPU R/W, low = write, asynchronous
Ncpu_rom_cs  input  1  /ROMSEL, low = $8000-$FFFF access, asynchronous
cpu_a14  input  1  CPU A14, passed combinationally to the PRG mux
cpu_d  input  8  CPU data bus, asynchronous
rom_d  input  8  PRG ROM output at the addressed byte, used for bus conflict
prg_a  output  BANK_BITS  PRG ROM A14..A(13+BANK_BITS)
bank_q  output  BANK_BITS  current committed bank register
write_strobe  output  1  one-clk pulse on each commit
busy  output  1  high while state != IDLE

Behaviour:
- Reset (rst sampled high at clk edge): bank_q=0, write_strobe=0, state=IDLE, low counter=0, synchronizer contents cleared to idle-bus values (m2=0, rw=1, romsel=1, data=0). Reset mid-cycle abandons any pending write without commit.
- Synchronizers: m2, Ncpu_rw, Ncpu_rom_cs pass through SYNC_STAGES flops. cpu_d and rom_d go through an identical-depth pipeline so data stays aligned with the control samples. s_* denotes the synchronized outputs.
- Low counter: 4-bit, saturating at MIN_LOW. Increments while s_romsel=0, s_rw=0, s_m2=1. Clears on any other sample.
- States:
  - IDLE: go to ARMED when counter reaches MIN_LOW.
  - ARMED: each clk latches cand = BUS_CONFLICT ? (s_cpu_d & s_rom_d) : s_cpu_d, truncated to low BANK_BITS.
    - s_romsel rises (1) -> COMMIT.
    - s_rw goes high while s_romsel still low -> IDLE, no commit (abort).
    - s_m2 falls while s_romsel low -> stay ARMED; cand is frozen while s_m2=0.
  - COMMIT (exactly 1 clk): bank_q <= cand, write_strobe=1, then IDLE.
- Commit latency: bank_q updates SYNC_STAGES+1 clk edges after the raw /ROMSEL rising edge.
- Simultaneous events: if s_romsel and s_rw rise on the same sample in ARMED, it is a commit, because the data was captured during the qualified low phase.
- Glitches: a /ROMSEL low pulse shorter than MIN_LOW synchronized samples is ignored, and bank_q is unchanged.
- Back-to-back writes: the next qualification can begin in the clk after COMMIT. Consecutive writes each produce exactly one strobe.
- prg_a: combinational. cpu_a14=0 -> bank_q; cpu_a14=1 -> all ones (last bank). No dependency on state.
- Truncation: data bits above BANK_BITS are discarded silently. Writing 0xFF with BANK_BITS=4 gives bank 15.
- busy = (state != IDLE).

Decomposition:
- Shared package unrom_pkg: state encoding (ST_IDLE=2'd0, ST_ARMED=2'd1, ST_COMMIT=2'd2), LAST_BANK constant function of BANK_BITS, default synchronizer reset values.
- One natural sub-module: unrom_sync, a parameterized N-bit, SYNC_STAGES-deep synchronizer with synchronous reset value. Instantiated for the control bits and for the 16-bit data pair.

Test Plan:
- Reset: rst high for 3 clk with random bus inputs -> bank_q=0, write_strobe=0, busy=0. cpu_a14=0 gives prg_a=0; cpu_a14=1 gives prg_a=4'hF.
- Basic write: CPU write cycle, cpu_d=0x05, rom_d=0xFF, /ROMSEL low 6 clk -> one write_strobe pulse SYNC_STAGES+1 clk after /ROMSEL rises; bank_q=5. cpu_a14=0 gives prg_a=5.
- Bus conflict: cpu_d=0x07, rom_d=0x05 -> bank_q=5. Repeat with BUS_CONFLICT=0 -> bank_q=7.
- Glitch filter: /ROMSEL low with R/W low for 2 clk, MIN_LOW=3, cpu_d=0x09 -> no strobe, bank_q unchanged.
- Read/abort: /ROMSEL low 6 clk with R/W high -> no strobe. A write qualified then R/W high before /ROMSEL rises -> abort, bank_q unchanged, busy returns to 0.
- Back-to-back and reset mid-op: writes 0x03 then 0x0C in consecutive M2 cycles -> two strobes, bank_q=0xC. A write reaching ARMED then rst asserted -> bank_q=0, no strobe.

Source files
------------

// File: rtl/unrom_pkg.sv
// Shared definitions for the UNROM bank controller.
// Holds the FSM state encoding, the bus sample payload types, the
// synchronizer reset values that represent an idle bus, and a helper
// that returns the index of the fixed last bank.
package unrom_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Control lines sampled from the cartridge bus
    typedef struct packed {
        logic m2;
        logic rw;
        logic romsel;
    } ctrl_t;

    // Data pair kept in lockstep with the control samples
    typedef struct packed {
        logic [DATA_W-1:0] cpu_d;
        logic [DATA_W-1:0] rom_d;
    } data_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);
    localparam int unsigned PAIR_W = $bits(data_t);

    // Idle bus: M2 low, read, /ROMSEL deasserted, data zero
    localparam ctrl_t CTRL_RST = '{m2: 1'b0, rw: 1'b1, romsel: 1'b1};
    localparam data_t DATA_RST = '{cpu_d: 8'h00, rom_d: 8'h00};

    // All-ones bank number for a register of the given width
    function automatic logic [15:0] last_bank(input int unsigned bits);
        return 16'((32'd1 << bits) - 32'd1);
    endfunction

endpackage

// File: rtl/unrom_sync.sv
// Multi-stage flop synchronizer with a synchronous reset value.
// Ports: clk, rst (sync, active high), d (async input), q (synchronized).
module unrom_sync
    import unrom_pkg::*;
#(
    parameter int unsigned     WIDTH   = 1,
    parameter int unsigned     STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain; stage 0 takes the raw input
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/unrom_bank_ctrl.sv
// UNROM bank controller.
// Oversamples the CPU cartridge bus, qualifies writes to $8000-$FFFF with
// a minimum-length filter, applies optional bus-conflict masking and
// commits the bank number; drives the PRG high address lines.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   m2, Ncpu_rw,      asynchronous CPU bus control
//   Ncpu_rom_cs
//   cpu_a14           selects switchable (0) or fixed last (1) bank
//   cpu_d, rom_d      CPU data and ROM data at the addressed byte
//   prg_a             PRG ROM high address (combinational)
//   bank_q            committed bank register
//   write_strobe      one-clk pulse per commit
//   busy              controller not idle
module unrom_bank_ctrl
    import unrom_pkg::*;
#(
    parameter int unsigned BANK_BITS    = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned MIN_LOW      = 3,
    parameter bit          BUS_CONFLICT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m2,
    input  logic                 Ncpu_rw,
    input  logic                 Ncpu_rom_cs,
    input  logic                 cpu_a14,
    input  logic [7:0]           cpu_d,
    input  logic [7:0]           rom_d,
    output logic [BANK_BITS-1:0] prg_a,
    output logic [BANK_BITS-1:0] bank_q,
    output logic                 write_strobe,
    output logic                 busy
);

    localparam logic [BANK_BITS-1:0] LAST = BANK_BITS'(last_bank(BANK_BITS));
    localparam logic [CNT_W-1:0]     SAT  = CNT_W'(MIN_LOW);

    ctrl_t                 ctrl_raw;
    ctrl_t                 s_ctrl;
    data_t                 data_raw;
    data_t                 s_data;
    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next_c;
    logic                  qualify_c;
    logic                  load_cand_c;
    logic                  commit_c;
    logic [DATA_W-1:0]     cand_src_c;
    logic [BANK_BITS-1:0]  cand;

    assign ctrl_raw = '{m2: m2, rw: Ncpu_rw, romsel: Ncpu_rom_cs};
    assign data_raw = '{cpu_d: cpu_d, rom_d: rom_d};

    unrom_sync #(
        .WIDTH   (CTRL_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (CTRL_RST)
    ) u_sync_ctrl (
        .clk (clk),
        .rst (rst),
        .d   (ctrl_raw),
        .q   (s_ctrl)
    );

    // Same depth as the control path so data stays aligned with its samples
    unrom_sync #(
        .WIDTH   (PAIR_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (DATA_RST)
    ) u_sync_data (
        .clk (clk),
        .rst (rst),
        .d   (data_raw),
        .q   (s_data)
    );

    // Qualifying sample: write with /ROMSEL low during M2 high
    assign qualify_c  = !s_ctrl.romsel && !s_ctrl.rw && s_ctrl.m2;
    assign cnt_next_c = !qualify_c   ? '0 :
                        (cnt >= SAT) ? SAT : cnt + CNT_W'(1);

    assign cand_src_c = BUS_CONFLICT ? (s_data.cpu_d & s_data.rom_d) : s_data.cpu_d;

    // State and low-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next_c;
        end
    end

    // Next state; a /ROMSEL rise wins over a simultaneous R/W rise
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cnt_next_c == SAT) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (s_ctrl.romsel)  state_next = ST_COMMIT;
                else if (s_ctrl.rw) state_next = ST_IDLE;
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Datapath controls; candidate is frozen while M2 is low
    always_comb begin
        load_cand_c = 1'b0;
        commit_c    = 1'b0;
        case (state)
            ST_IDLE:  load_cand_c = (state_next == ST_ARMED);
            ST_ARMED: begin
                load_cand_c = s_ctrl.m2 && !s_ctrl.romsel && !s_ctrl.rw;
                commit_c    = (state_next == ST_COMMIT);
            end
            default: ;
        endcase
    end

    // Bank register and status outputs; both update on entry to COMMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            cand         <= '0;
            bank_q       <= '0;
            write_strobe <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (load_cand_c) cand   <= BANK_BITS'(cand_src_c);
            if (commit_c)    bank_q <= cand;
            write_strobe <= commit_c;
            busy         <= (state_next != ST_IDLE);
        end
    end

    assign prg_a = cpu_a14 ? LAST : bank_q;

endmodule
